// File: rtl/dreimann_turn_fsm_if.sv
// Signal bundle between dice_controller (master side) and the Drei-Mann turn
// FSM (slave side). NUM_PLAYERS sets the player-index width the same way the
// FSM derives it.
//
// Handshake: 'rolled' is a one-cycle valid strobe qualifying stored_value.
// There is no ready wire. 'busy' is the inverse of ready. A strobe that
// arrives while busy is dropped and flagged on 'error'.
//
// Optional feature macro: DREIMANN_SCORE_EN adds score_sel / score_out.
interface dreimann_turn_fsm_if #(
  parameter int NUM_PLAYERS = 3
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic          rolled;
  logic [2:0]    stored_value;
  logic          new_game;
  logic [PW-1:0] current_player;
  logic [PW-1:0] dreimann_id;
  logic          dreimann_valid;
  logic [1:0]    event_code;
  logic          event_valid;
  logic [3:0]    roll_count;
  logic          busy;
  logic          error;
`ifdef DREIMANN_SCORE_EN
  logic [PW-1:0] score_sel;
  logic [3:0]    score_out;

  modport master (
    output rolled, stored_value, new_game, score_sel,
    input  current_player, dreimann_id, dreimann_valid, event_code,
           event_valid, roll_count, busy, error, score_out
  );
  modport slave (
    input  rolled, stored_value, new_game, score_sel,
    output current_player, dreimann_id, dreimann_valid, event_code,
           event_valid, roll_count, busy, error, score_out
  );
`else
  modport master (
    output rolled, stored_value, new_game,
    input  current_player, dreimann_id, dreimann_valid, event_code,
           event_valid, roll_count, busy, error
  );
  modport slave (
    input  rolled, stored_value, new_game,
    output current_player, dreimann_id, dreimann_valid, event_code,
           event_valid, roll_count, busy, error
  );
`endif
endinterface

// File: rtl/dreimann_turn_fsm.sv
// Drei-Mann turn logic. It consumes the latched die value from
// dice_controller and tracks the current player, the current Dreimann and the
// rolls taken in this turn. Each accepted roll takes one EVAL cycle and then
// HOLD_CYCLES ANNOUNCE cycles. busy is high for that whole window.
//
// Optional feature macro: DREIMANN_SCORE_EN adds per-player saturating
// Dreimann counters, read through score_sel / score_out.
module dreimann_turn_fsm #(
  parameter int NUM_PLAYERS = 3,
  parameter int MAX_ROLLS   = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dreimann_turn_fsm_if.slave bus,
  output logic [1:0]         fsm_state
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [PW-1:0] LAST_P    = PW'(NUM_PLAYERS - 1);
  localparam logic [4:0]    MAX_R     = 5'(MAX_ROLLS);
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD_CYCLES - 1);

  localparam logic [1:0] EV_NONE  = 2'b00;
  localparam logic [1:0] EV_PASS  = 2'b01;
  localparam logic [1:0] EV_AGAIN = 2'b10;
  localparam logic [1:0] EV_DREI  = 2'b11;

  typedef enum logic [1:0] {
    S_WAIT     = 2'd0,
    S_EVAL     = 2'd1,
    S_ANNOUNCE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [2:0]    value_q, value_d;
  logic [PW-1:0] player_q, player_d;
  logic [PW-1:0] dm_id_q, dm_id_d;
  logic          dm_valid_q, dm_valid_d;
  logic [1:0]    code_q, code_d;
  logic          ev_valid_q, ev_valid_d;
  logic [3:0]    rc_q, rc_d;
  logic          error_q, error_d;

  logic [PW-1:0] player_adv;
  logic [4:0]    rc_next;

  assign player_adv = (player_q == LAST_P) ? '0 : player_q + 1'b1;
  assign rc_next    = {1'b0, rc_q} + 5'd1;

`ifdef DREIMANN_SCORE_EN
  logic score_inc;
`endif

  // State and game registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT;
      hold_q     <= '0;
      value_q    <= '0;
      player_q   <= '0;
      dm_id_q    <= '0;
      dm_valid_q <= 1'b0;
      code_q     <= EV_NONE;
      ev_valid_q <= 1'b0;
      rc_q       <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      value_q    <= value_d;
      player_q   <= player_d;
      dm_id_q    <= dm_id_d;
      dm_valid_q <= dm_valid_d;
      code_q     <= code_d;
      ev_valid_q <= ev_valid_d;
      rc_q       <= rc_d;
      error_q    <= error_d;
    end
  end

  // Next state and turn rules. new_game overrides everything, including a coincident roll.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    value_d    = value_q;
    player_d   = player_q;
    dm_id_d    = dm_id_q;
    dm_valid_d = dm_valid_q;
    code_d     = code_q;
    ev_valid_d = 1'b0;
    rc_d       = rc_q;
    // A strobe outside WAIT cannot be taken, so it is dropped and remembered.
    error_d    = error_q | (bus.rolled && (state_q != S_WAIT));
`ifdef DREIMANN_SCORE_EN
    score_inc  = 1'b0;
`endif

    case (state_q)
      S_WAIT: begin
        if (bus.rolled) begin
          value_d = bus.stored_value;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        state_d    = S_ANNOUNCE;
        hold_d     = '0;
        ev_valid_d = 1'b1;
        case (value_q)
          3'd3: begin
            dm_id_d    = player_q;
            dm_valid_d = 1'b1;
            code_d     = EV_DREI;
            player_d   = player_adv;
            rc_d       = '0;
`ifdef DREIMANN_SCORE_EN
            score_inc  = 1'b1;
`endif
          end
          3'd6: begin
            if (rc_next < MAX_R) begin
              code_d = EV_AGAIN;
              rc_d   = rc_next[3:0];
            end else begin
              code_d   = EV_PASS;
              player_d = player_adv;
              rc_d     = '0;
            end
          end
          3'd1, 3'd2, 3'd4, 3'd5: begin
            code_d   = EV_PASS;
            player_d = player_adv;
            rc_d     = '0;
          end
          default: begin
            // A die value of 0 or 7 is illegal. Flag it and leave the game state unchanged.
            code_d  = EV_NONE;
            error_d = 1'b1;
          end
        endcase
      end
      S_ANNOUNCE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_WAIT;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_WAIT;
    endcase

    if (bus.new_game) begin
      state_d    = S_WAIT;
      hold_d     = '0;
      value_d    = '0;
      player_d   = '0;
      dm_id_d    = '0;
      dm_valid_d = 1'b0;
      code_d     = EV_NONE;
      ev_valid_d = 1'b0;
      rc_d       = '0;
      error_d    = 1'b0;
`ifdef DREIMANN_SCORE_EN
      score_inc  = 1'b0;
`endif
    end
  end

  assign bus.current_player = player_q;
  assign bus.dreimann_id    = dm_id_q;
  assign bus.dreimann_valid = dm_valid_q;
  assign bus.event_code     = code_q;
  assign bus.event_valid    = ev_valid_q;
  assign bus.roll_count     = rc_q;
  assign bus.busy           = (state_q != S_WAIT);
  assign bus.error          = error_q;
  assign fsm_state          = state_q;

`ifdef DREIMANN_SCORE_EN
  localparam logic [PW:0] NP_W = (PW+1)'(NUM_PLAYERS);

  logic [3:0] score_q [NUM_PLAYERS];

  // Per-player Dreimann counters. They saturate at 15 and are cleared by new_game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else if (bus.new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else if (score_inc && (score_q[player_q] != 4'hF)) begin
      score_q[player_q] <= score_q[player_q] + 4'd1;
    end
  end

  assign bus.score_out = ({1'b0, bus.score_sel} < NP_W) ? score_q[bus.score_sel] : 4'd0;
`endif

endmodule
